// File: rtl/uart_prog_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART and writes
// little-endian 32-bit words into instruction BRAM, holding the core until done.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} ld_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  ld_state_e        ld_state_q, ld_state_d;
  logic [15:0]      len_q, len_d, len_new;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  core_hold_q, core_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  // Receiver: half-bit wait re-checks the start bit, then one sample per bit period.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (clk_cnt_q == HALF_LAST) begin
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (clk_cnt_q == BIT_LAST) begin
        clk_cnt_d = '0;
        shift_d   = {rx_sync_q, shift_q[7:1]};
        if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        else                   bit_cnt_d  = bit_cnt_q + 3'd1;
      end
      RX_STOP: if (clk_cnt_q == BIT_LAST) begin
        clk_cnt_d    = '0;
        rx_state_d   = RX_IDLE;
        byte_valid_d = rx_sync_q;
        frame_err_d  = !rx_sync_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign len_new = {shift_q, len_q[7:0]};

  always_comb begin
    ld_state_d  = ld_state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (ld_state_q)
      LEN_LO: begin
        if (frame_err_q) ld_state_d = ERROR;
        else if (byte_valid_q) begin
          len_d[7:0] = shift_q;
          ld_state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (frame_err_q) ld_state_d = ERROR;
        else if (byte_valid_q) begin
          len_d = len_new;
          if (len_new == 16'd0)                ld_state_d = DONE;
          else if (32'(len_new) > MAX_WORDS)   ld_state_d = ERROR;
          else                                 ld_state_d = DATA;
        end
      end
      DATA: begin
        if (frame_err_q) ld_state_d = ERROR;
        else if (byte_valid_q) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word: write it and advance the index together.
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q, word_q[23:0]};
            mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
            idx_d       = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(len_q)) ld_state_d = DONE;
          end
        end
      end
      default: ;
    endcase
    core_hold_d  = (ld_state_q != DONE);
    load_done_d  = (ld_state_q == DONE);
    load_error_d = (ld_state_q == ERROR);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_state_q   <= LEN_LO;
      len_q        <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_state_q   <= ld_state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a byte-stream reference model predicts
// BRAM writes and final status; a negedge monitor checks every write strobe.
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int MAXW = 1 << AW;

  typedef logic [7:0] u8_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold, load_done, load_error;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  we_cyc   = -1;
  int  done_cyc = -1;
  int  wr_count = 0;
  bit  prev_we  = 1'b0;
  bit  prev_done = 1'b0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      wr_count++;
      check("we_single_cycle", prev_we, 1'b0);
      check("write_was_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_wdata, e.data);
      end
      we_cyc = cyc;
    end
    if (load_done && !prev_done) begin
      done_cyc = cyc;
      check("core_hold_released_at_done", core_hold, 1'b0);
    end
    prev_we   = mem_we;
    prev_done = load_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input u8_t b, input bit good_stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = good_stop;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    check({tag, "_rst_core_hold"}, core_hold, 1'b1);
    check({tag, "_rst_we"}, mem_we, 1'b0);
    check({tag, "_rst_done"}, load_done, 1'b0);
    check({tag, "_rst_error"}, load_error, 1'b0);
    check({tag, "_rst_addr"}, mem_addr, '0);
    check({tag, "_rst_wdata"}, mem_wdata, '0);
    exp_q.delete();
    wr_count = 0;
    we_cyc   = -1;
    done_cyc = -1;
    rst = 1'b1;
    tick(2);
  endtask

  // Reference model: interpret the byte stream as <len_lo len_hi word*len>.
  // bad_idx marks the byte sent with a broken stop bit (-1 = none).
  task automatic model(input u8_t s[$], input int bad_idx,
                       output bit exp_done, output bit exp_err, output int nw);
    int len, avail;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    nw       = 0;
    if (bad_idx >= 0 && bad_idx < 2) begin
      exp_err = 1'b1;
      return;
    end
    if (s.size() < 2) return;
    len = int'(s[0]) + 256 * int'(s[1]);
    if (len == 0) begin
      exp_done = 1'b1;
      return;
    end
    if (len > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    avail = ((bad_idx >= 0) ? bad_idx : s.size()) - 2;
    nw = (avail / 4 < len) ? avail / 4 : len;
    for (int i = 0; i < nw; i++) begin
      wr_t w;
      w.addr = AW'(i);
      w.data = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      exp_q.push_back(w);
    end
    if (nw == len) exp_done = 1'b1;
    else if (bad_idx >= 0) exp_err = 1'b1;
  endtask

  task automatic run_stream(input string tag, input u8_t s[$], input int bad_idx);
    bit ed, ee;
    int nw;
    int wr_start;
    wr_start = wr_count;
    model(s, bad_idx, ed, ee, nw);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], i != bad_idx);
    tick(20);
    check({tag, "_all_writes_seen"}, exp_q.size(), 0);
    check({tag, "_write_count"}, wr_count - wr_start, nw);
    check({tag, "_load_done"}, load_done, ed);
    check({tag, "_load_error"}, load_error, ee);
    check({tag, "_core_hold"}, core_hold, !ed);
    if (ed && nw > 0) check({tag, "_done_one_cycle_after_last_we"}, done_cyc - we_cyc, 1);
  endtask

  // Bytes after DONE/ERROR must never produce a write or change status.
  task automatic send_ignored(input string tag, input u8_t s[$]);
    bit d0, e0;
    int wr_start;
    d0 = load_done;
    e0 = load_error;
    wr_start = wr_count;
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b1);
    tick(20);
    check({tag, "_no_writes"}, wr_count - wr_start, 0);
    check({tag, "_done_sticky"}, load_done, d0);
    check({tag, "_error_sticky"}, load_error, e0);
  endtask

  function automatic void rand_image(ref u8_t s[$], input int len, input int data_bytes);
    s.delete();
    s.push_back(u8_t'(len & 8'hFF));
    s.push_back(u8_t'((len >> 8) & 8'hFF));
    for (int i = 0; i < data_bytes; i++) s.push_back(u8_t'($urandom_range(255)));
  endfunction

  initial begin
    u8_t s[$];
    int  len;

    do_reset("init");
    tick(100);
    check("idle_core_hold", core_hold, 1'b1);
    check("idle_we_count", wr_count, 0);
    check("idle_done", load_done, 1'b0);
    check("idle_error", load_error, 1'b0);

    // One-cycle glitch must not be taken as a byte; the following load proves alignment.
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(50);
    check("glitch_no_error", load_error, 1'b0);
    s = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_stream("basic", s, -1);
    s = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_ignored("after_done", s);

    do_reset("zero");
    s = {8'h00, 8'h00};
    run_stream("zero_len", s, -1);

    do_reset("over");
    s = {8'h11, 8'h00};
    run_stream("oversize", s, -1);
    s = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_ignored("after_oversize", s);

    do_reset("max");
    rand_image(s, MAXW, 4 * MAXW);
    run_stream("max_len", s, -1);

    do_reset("ferr");
    rand_image(s, 3, 8);
    run_stream("frame_in_data", s, 6);
    s = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_ignored("after_frame_err", s);

    do_reset("ferr_len");
    s = {8'h01, 8'h00};
    run_stream("frame_in_len", s, 0);

    do_reset("midrst");
    rand_image(s, 2, 5);
    run_stream("partial", s, -1);
    do_reset("midrst2");
    s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_stream("after_midrst", s, -1);

    for (int t = 0; t < 4; t++) begin
      do_reset("rnd");
      len = $urandom_range(6, 1);
      rand_image(s, len, 4 * len);
      run_stream("rand_load", s, -1);
    end

    do_reset("rnd_over");
    rand_image(s, $urandom_range(65535, MAXW + 1), 4);
    run_stream("rand_oversize", s, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
